// File: rtl/alu_cmd_driver.sv
// ============================================================================
// Module   : alu_cmd_driver
// Purpose  : Command/response initiator for the 8-bit combinational ALU,
//            with an accumulator for chained operations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_driver #(
    parameter int         CNT_W   = 16,
    parameter logic [7:0] ACC_RST = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_use_acc,
    output logic [2:0]       alu_opcode,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [7:0]       alu_salida,
    input  logic [7:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic [7:0]       rsp_flags,
    output logic [7:0]       acc_value,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ALU operand registers only change on accept, keeping the ALU output
    // stable for the whole response phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_opcode <= 3'd0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            rsp_result <= 8'h00;
            rsp_flags  <= 8'h00;
            acc_value  <= ACC_RST;
            op_count   <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                alu_opcode <= cmd_opcode;
                alu_b      <= cmd_b;
                alu_a      <= cmd_use_acc ? acc_value : cmd_a;
            end
            if (state == ISSUE) begin
                rsp_result <= alu_salida;
                rsp_flags  <= alu_flags;
                acc_value  <= alu_salida;
            end
            if (state == RESP && rsp_ready) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
// ============================================================================
// Module   : tb_alu_cmd_driver
// Purpose  : Directed self-checking bench for alu_cmd_driver with a small
//            behavioural ALU attached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_driver;

    localparam int         CNT_W   = 2;
    localparam logic [7:0] ACC_RST = 8'hA5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_opcode = 3'd0;
    logic [7:0]       cmd_a = 8'h00;
    logic [7:0]       cmd_b = 8'h00;
    logic             cmd_use_acc = 1'b0;
    logic [2:0]       alu_opcode;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [7:0]       alu_salida;
    logic [7:0]       alu_flags;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [7:0]       rsp_result;
    logic [7:0]       rsp_flags;
    logic [7:0]       acc_value;
    logic [CNT_W-1:0] op_count;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.CNT_W(CNT_W), .ACC_RST(ACC_RST)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_salida(alu_salida), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .acc_value(acc_value), .op_count(op_count)
    );

    // Behavioural ALU; flags: N, Z, C, V, G(a>b), Q(a==b), O, P(parity).
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide = 9'd0;
        case (alu_opcode)
            3'b000, 3'b010: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001, 3'b011: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            3'b100, 3'b110: alu_wide = {1'b0, alu_a << alu_b[2:0]};
            default:        alu_wide = {1'b0, alu_a >> alu_b[2:0]};
        endcase
        alu_salida = alu_wide[7:0];
        alu_flags  = {alu_wide[7], (alu_wide[7:0] == 8'h00), alu_wide[8], 1'b0,
                      (alu_a > alu_b), (alu_a == alu_b), 1'b0, ^alu_wide[7:0]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full transaction with rsp_ready held high; inputs change on negedge.
    task automatic do_op(input string tag, input logic [2:0] opc, input logic [7:0] a,
                         input logic [7:0] b, input logic use_acc,
                         input logic [7:0] exp_a, input logic [7:0] exp_res,
                         input logic [CNT_W-1:0] exp_cnt);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = opc; cmd_a = a; cmd_b = b;
        cmd_use_acc = use_acc; rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({tag, "_ready_issue"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_alu_a"}, 32'(alu_a), 32'(exp_a));
        chk({tag, "_valid_issue"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid_resp"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
        chk({tag, "_acc"}, 32'(acc_value), 32'(exp_res));
        @(negedge clk);
        chk({tag, "_valid_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready_done"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_count"}, 32'(op_count), 32'(exp_cnt));
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_acc", 32'(acc_value), 32'(ACC_RST));
        chk("rst_count", 32'(op_count), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_result", 32'(rsp_result), 32'd0);
        rst = 1'b0;

        // Basic add: 5+3
        do_op("add", 3'b010, 8'h05, 8'h03, 1'b0, 8'h05, 8'h08, 2'd1);
        chk("add_flagZ", 32'(rsp_flags[6]), 32'd0);
        chk("add_flags", 32'(rsp_flags), 32'h09);
        chk("add_opc", 32'(alu_opcode), 32'd2);
        chk("add_b", 32'(alu_b), 32'h03);

        // Shift and zero result
        do_op("shl", 3'b100, 8'h01, 8'h03, 1'b0, 8'h01, 8'h08, 2'd2);
        do_op("sub", 3'b011, 8'h04, 8'h04, 1'b0, 8'h04, 8'h00, 2'd3);
        chk("sub_flagZ", 32'(rsp_flags[6]), 32'd1);
        chk("sub_flagQ", 32'(rsp_flags[2]), 32'd1);

        // Accumulator chaining
        do_op("chain0", 3'b010, 8'h10, 8'h01, 1'b0, 8'h10, 8'h11, 2'd0);
        do_op("chain1", 3'b010, 8'hFF, 8'h02, 1'b1, 8'h11, 8'h13, 2'd1);

        // Backpressure
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 3'b010; cmd_a = 8'h20; cmd_b = 8'h01;
        cmd_use_acc = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        cmd_a = 8'h30; cmd_b = 8'h02;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_result", 32'(rsp_result), 32'h21);
            chk("bp_ready", 32'(cmd_ready), 32'd0);
            chk("bp_alu_a", 32'(alu_a), 32'h20);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_valid", 32'(rsp_valid), 32'd0);
        chk("bp_hs_ready", 32'(cmd_ready), 32'd1);
        chk("bp_hs_count", 32'(op_count), 32'd2);
        chk("bp_hs_alu_a", 32'(alu_a), 32'h20);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp2_alu_a", 32'(alu_a), 32'h30);
        chk("bp2_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("bp2_valid", 32'(rsp_valid), 32'd1);
        chk("bp2_result", 32'(rsp_result), 32'h32);
        @(negedge clk);
        chk("bp2_count", 32'(op_count), 32'd3);

        // Reset during ISSUE
        cmd_valid = 1'b1; cmd_opcode = 3'b010; cmd_a = 8'h40; cmd_b = 8'h01;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_in_issue", 32'(cmd_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_valid", 32'(rsp_valid), 32'd0);
        chk("mid_ready", 32'(cmd_ready), 32'd1);
        chk("mid_acc", 32'(acc_value), 32'(ACC_RST));
        chk("mid_count", 32'(op_count), 32'd0);
        chk("mid_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_valid", 32'(rsp_valid), 32'd0);
            chk("post_count", 32'(op_count), 32'd0);
            chk("post_acc", 32'(acc_value), 32'(ACC_RST));
        end

        // Counter wrap with CNT_W=2: 1,2,3,0,1
        do_op("wrap1", 3'b101, 8'h80, 8'h01, 1'b0, 8'h80, 8'h40, 2'd1);
        do_op("wrap2", 3'b111, 8'h80, 8'h03, 1'b1, 8'h40, 8'h08, 2'd2);
        do_op("wrap3", 3'b001, 8'h00, 8'h01, 1'b0, 8'h00, 8'hFF, 2'd3);
        chk("wrap3_flagN", 32'(rsp_flags[7]), 32'd1);
        do_op("wrap4", 3'b000, 8'h00, 8'h01, 1'b1, 8'hFF, 8'h00, 2'd0);
        chk("wrap4_flagC", 32'(rsp_flags[5]), 32'd1);
        do_op("wrap5", 3'b110, 8'h03, 8'h02, 1'b0, 8'h03, 8'h0C, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
